// File: rtl/mips_pkg.sv
// Shared definitions for the mips32 hazard/stall logic and the HI/LO datapath.
// Keeps the FSM encoding and latency defaults in one place.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF  = 32;

  localparam int MD_CNT_W = 6;

  // $zero never creates a dependency
  function automatic logic src_match(
    input logic [4:0] src,
    input logic [4:0] dst
  );
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hilo_sequencer.sv
// HI/LO multicycle unit sequencer: IDLE -> BUSY (latency count) -> DONE.
// DONE is the single-cycle HI/LO write strobe.
module hilo_sequencer
  import mips_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic is_div_i,
  input  logic mem_stall_i,
  output logic busy_o,
  output logic done_o
);

  localparam logic [MD_CNT_W-1:0] MULT_CNT =
    MD_CNT_W'(MULT_LATENCY - 1);
  localparam logic [MD_CNT_W-1:0] DIV_CNT =
    MD_CNT_W'(DIV_LATENCY - 1);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && !mem_stall_i) begin
          state_d = MD_BUSY;
          cnt_d   = is_div_i ? DIV_CNT : MULT_CNT;
        end
      end
      MD_BUSY: begin
        // count runs through freezes
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/hazard_controller.sv
// mips32 hazard/stall controller: load-use, branch-in-ID, HI/LO
// and data-memory stalls, plus a saturating stall-cycle counter.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int DIV_LATENCY  = DIV_LATENCY_DEF,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           rsID,
  input  logic [4:0]           rtID,
  input  logic                 useRtID,
  input  logic                 branchID,
  input  logic                 hiloReadID,
  input  logic                 mdID,
  input  logic [4:0]           destRegEX,
  input  logic [4:0]           destRegMEM,
  input  logic                 regWriteEX,
  input  logic                 memReadEX,
  input  logic                 memReadMEM,
  input  logic                 mdStartEX,
  input  logic                 mdIsDivEX,
  input  logic                 memStall,
  output logic                 stallPC,
  output logic                 stallIFID,
  output logic                 flushIDEX,
  output logic                 freeze,
  output logic                 mdBusy,
  output logic                 mdDone,
  output logic [CNT_WIDTH-1:0] stallCycles
);

  logic matchEX, matchMEM;
  logic loadUse, branchHaz, mdHaz;
  logic idStall, anyStall;
  logic [CNT_WIDTH-1:0] sc_q, sc_d;

  hilo_sequencer #(
    .MULT_LATENCY(MULT_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_hilo (
    .clk_i      (clock),
    .rst_i      (reset),
    .start_i    (mdStartEX),
    .is_div_i   (mdIsDivEX),
    .mem_stall_i(memStall),
    .busy_o     (mdBusy),
    .done_o     (mdDone)
  );

  assign matchEX = src_match(rsID, destRegEX)
    | (useRtID & src_match(rtID, destRegEX));
  assign matchMEM = src_match(rsID, destRegMEM)
    | (useRtID & src_match(rtID, destRegMEM));

  assign loadUse = memReadEX & regWriteEX & matchEX;

  // ALU results in EX/MEM are forwardable to ID; loads are not
  assign branchHaz = branchID & (
    (regWriteEX & memReadEX & matchEX) |
    (memReadMEM & matchMEM));

  assign mdHaz = (hiloReadID | mdID) & mdBusy;

  assign idStall  = loadUse | branchHaz | mdHaz;
  assign anyStall = ~reset & (idStall | memStall);

  assign freeze    = ~reset & memStall;
  assign stallPC   = anyStall;
  assign stallIFID = anyStall;
  assign flushIDEX = ~reset & idStall & ~memStall;

  always_comb begin
    sc_d = sc_q;
    if (anyStall && !(&sc_q)) begin
      sc_d = sc_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign stallCycles = sc_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_controller;

  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rsID = '0, rtID = '0;
  logic          useRtID = 0, branchID = 0;
  logic          hiloReadID = 0, mdID = 0;
  logic [4:0]    destRegEX = '0, destRegMEM = '0;
  logic          regWriteEX = 0, memReadEX = 0;
  logic          memReadMEM = 0;
  logic          mdStartEX = 0, mdIsDivEX = 0;
  logic          memStall = 0;
  logic          stallPC, stallIFID, flushIDEX, freeze;
  logic          mdBusy, mdDone;
  logic [CW-1:0] stallCycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic          sp;
    logic          fl;
    logic          fz;
    logic          bz;
    logic          dn;
    logic [CW-1:0] sc;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] sc = '0;

  hazard_controller #(
    .MULT_LATENCY(4),
    .DIV_LATENCY (32),
    .CNT_WIDTH   (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rsID       (rsID),
    .rtID       (rtID),
    .useRtID    (useRtID),
    .branchID   (branchID),
    .hiloReadID (hiloReadID),
    .mdID       (mdID),
    .destRegEX  (destRegEX),
    .destRegMEM (destRegMEM),
    .regWriteEX (regWriteEX),
    .memReadEX  (memReadEX),
    .memReadMEM (memReadMEM),
    .mdStartEX  (mdStartEX),
    .mdIsDivEX  (mdIsDivEX),
    .memStall   (memStall),
    .stallPC    (stallPC),
    .stallIFID  (stallIFID),
    .flushIDEX  (flushIDEX),
    .freeze     (freeze),
    .mdBusy     (mdBusy),
    .mdDone     (mdDone),
    .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string         tag,
    input string         sig,
    input logic [CW-1:0] obs,
    input logic [CW-1:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h",
             tag, sig, obs, exp);
    end
  endtask

  task automatic clr();
    rsID = '0; rtID = '0; useRtID = 0; branchID = 0;
    hiloReadID = 0; mdID = 0;
    destRegEX = '0; destRegMEM = '0;
    regWriteEX = 0; memReadEX = 0; memReadMEM = 0;
    mdStartEX = 0; mdIsDivEX = 0; memStall = 0;
  endtask

  // one cycle: push expectation, check it, advance to next falling edge
  task automatic cyc(
    input string tag,
    input logic  sp,
    input logic  fl,
    input logic  fz,
    input logic  bz,
    input logic  dn
  );
    exp_t e;
    exp_t got;
    e.tag = tag; e.sp = sp; e.fl = fl; e.fz = fz;
    e.bz = bz; e.dn = dn; e.sc = sc;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    chk(got.tag, "stallPC",     CW'(stallPC),   CW'(got.sp));
    chk(got.tag, "stallIFID",   CW'(stallIFID), CW'(got.sp));
    chk(got.tag, "flushIDEX",   CW'(flushIDEX), CW'(got.fl));
    chk(got.tag, "freeze",      CW'(freeze),    CW'(got.fz));
    chk(got.tag, "mdBusy",      CW'(mdBusy),    CW'(got.bz));
    chk(got.tag, "mdDone",      CW'(mdDone),    CW'(got.dn));
    chk(got.tag, "stallCycles", stallCycles,    got.sc);
    if (sp && sc != '1) sc = sc + 1'b1;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    // hazard inputs active while in reset: outputs must stay 0
    memReadEX = 1; regWriteEX = 1; destRegEX = 5'd8;
    rsID = 5'd8; memStall = 1; hiloReadID = 1;
    cyc("in_reset", 0, 0, 0, 0, 0);
    reset = 0;
    clr();
    cyc("idle", 0, 0, 0, 0, 0);

    // lw $t0 in EX, add using $t0 in ID
    memReadEX = 1; regWriteEX = 1; destRegEX = 5'd8;
    rsID = 5'd8; rtID = 5'd10; useRtID = 1;
    cyc("lu_ex", 1, 1, 0, 0, 0);
    clr();
    memReadMEM = 1; destRegMEM = 5'd8;
    rsID = 5'd8; rtID = 5'd10; useRtID = 1;
    cyc("lu_after", 0, 0, 0, 0, 0);

    // beq $t0,$zero behind lw $t0
    clr();
    branchID = 1; rsID = 5'd8; rtID = 5'd0; useRtID = 1;
    memReadEX = 1; regWriteEX = 1; destRegEX = 5'd8;
    cyc("br_ld_ex", 1, 1, 0, 0, 0);
    memReadEX = 0; regWriteEX = 0; destRegEX = 5'd0;
    memReadMEM = 1; destRegMEM = 5'd8;
    cyc("br_ld_mem", 1, 1, 0, 0, 0);
    memReadMEM = 0; destRegMEM = 5'd0;
    cyc("br_ld_wb", 0, 0, 0, 0, 0);
    // same beq behind an add writing $t0
    regWriteEX = 1; destRegEX = 5'd8;
    cyc("br_alu_ex", 0, 0, 0, 0, 0);
    regWriteEX = 0; destRegEX = 5'd0; destRegMEM = 5'd8;
    cyc("br_alu_mem", 0, 0, 0, 0, 0);

    // $zero and unused rt never cause a stall
    clr();
    memReadEX = 1; regWriteEX = 1; destRegEX = 5'd0;
    rsID = 5'd0; rtID = 5'd0; useRtID = 1;
    cyc("zero_reg", 0, 0, 0, 0, 0);
    destRegEX = 5'd9; rsID = 5'd3; rtID = 5'd9; useRtID = 0;
    cyc("rt_unused", 0, 0, 0, 0, 0);
    useRtID = 1;
    cyc("rt_used", 1, 1, 0, 0, 0);

    // mult offered during memStall is not accepted
    clr();
    mdStartEX = 1; memStall = 1;
    cyc("md_frozen", 1, 0, 1, 0, 0);
    mdStartEX = 0; memStall = 0;
    cyc("md_not_taken", 0, 0, 0, 0, 0);

    // mult: 4 busy cycles, then DONE; restart attempts ignored
    mdStartEX = 1;
    cyc("mult_start", 0, 0, 0, 0, 0);
    mdID = 1; mdIsDivEX = 1;
    for (int i = 0; i < 4; i++) cyc("mult_busy", 1, 1, 0, 1, 0);
    mdStartEX = 0; mdIsDivEX = 0;
    cyc("mult_done", 1, 1, 0, 1, 1);
    cyc("mult_idle", 0, 0, 0, 0, 0);

    // div then mflo: busy 33 cycles, done on the 33rd
    clr();
    mdStartEX = 1; mdIsDivEX = 1;
    cyc("div_start", 0, 0, 0, 0, 0);
    clr();
    hiloReadID = 1;
    for (int i = 0; i < 32; i++) cyc("div_busy", 1, 1, 0, 1, 0);
    cyc("div_done", 1, 1, 0, 1, 1);
    cyc("mflo_go", 0, 0, 0, 0, 0);

    // memStall during load-use: 3 frozen cycles, then the bubble
    clr();
    memReadEX = 1; regWriteEX = 1; destRegEX = 5'd8; rsID = 5'd8;
    memStall = 1;
    for (int i = 0; i < 3; i++) cyc("frz_lu", 1, 0, 1, 0, 0);
    memStall = 0;
    cyc("frz_bubble", 1, 1, 0, 0, 0);
    clr();
    cyc("frz_clear", 0, 0, 0, 0, 0);

    // reset while BUSY with cnt=10
    mdStartEX = 1; mdIsDivEX = 1;
    cyc("rb_start", 0, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 22; i++) cyc("rb_busy", 0, 0, 0, 1, 0);
    reset = 1; sc = '0;
    hiloReadID = 1; memStall = 1;
    memReadEX = 1; regWriteEX = 1; destRegEX = 5'd8; rsID = 5'd8;
    cyc("rb_reset", 0, 0, 0, 0, 0);
    reset = 0;
    clr();
    for (int i = 0; i < 40; i++) cyc("rb_idle", 0, 0, 0, 0, 0);

    // saturation of stallCycles
    memStall = 1;
    for (int i = 0; i < (1 << CW) + 5; i++) @(negedge clock);
    sc = '1;
    cyc("sat_a", 1, 0, 1, 0, 0);
    cyc("sat_b", 1, 0, 1, 0, 0);
    clr();
    cyc("sat_hold", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
